// File: rtl/btb_ctrl.sv
// Branch target buffer controller: keeps tags, valid bits and 2-bit direction
// counters in flops and drives a dual-port target SRAM (port 0 lookup, port 1 update).
module btb_ctrl #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [XLEN-1:0]       lookup_pc,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_taken,
  output logic [XLEN-1:0]       resp_target,
  input  logic                  update_valid,
  input  logic [XLEN-1:0]       update_pc,
  input  logic                  update_taken,
  input  logic [XLEN-1:0]       update_target,
  input  logic                  flush,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [INDEX_BITS-1:0] sram_addr0,
  output logic [XLEN-1:0]       sram_din0,
  input  logic [XLEN-1:0]       sram_dout0,
  output logic                  sram_csb1,
  output logic                  sram_web1,
  output logic [INDEX_BITS-1:0] sram_addr1,
  output logic [XLEN-1:0]       sram_din1,
  input  logic [XLEN-1:0]       sram_dout1
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [1:0]          ctr_q [ENTRIES];

  logic                resp_v_q;
  logic                snap_valid_q;
  logic [TAG_BITS-1:0] snap_tag_q;
  logic [1:0]          snap_ctr_q;
  logic [TAG_BITS-1:0] lk_tag_q;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic [1:0]            up_ctr;
  logic                  up_hit, up_en, alloc, write_en;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign lk_tag = lookup_pc[XLEN-1:INDEX_BITS+2];
  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag = update_pc[XLEN-1:INDEX_BITS+2];
  assign up_ctr = ctr_q[up_idx];

  // Flush wins over a same-cycle update; only taken outcomes touch the SRAM.
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en    = update_valid && !flush;
  assign alloc    = up_en && !up_hit && update_taken;
  assign write_en = up_en && update_taken;

  assign sram_csb0  = !(rst_n && lookup_valid);
  assign sram_web0  = 1'b1;
  assign sram_addr0 = lk_idx;
  assign sram_din0  = '0;

  assign sram_csb1  = !(rst_n && write_en);
  assign sram_web1  = 1'b0;
  assign sram_addr1 = up_idx;
  assign sram_din1  = update_target;

  // NOTE: sequential state uses non-blocking assignments so every same-edge
  // reader (the lookup snapshot below) sees the pre-update values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= 2'd2;
    end else if (up_en && up_hit) begin
      if (update_taken) ctr_q[up_idx] <= (up_ctr == 2'd3) ? 2'd3 : up_ctr + 2'd1;
      else              ctr_q[up_idx] <= (up_ctr == 2'd0) ? 2'd0 : up_ctr - 2'd1;
    end
  end

  // NOTE: tag storage is a plain memory with no reset; valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (alloc) tag_q[up_idx] <= up_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_v_q     <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_tag_q   <= '0;
      snap_ctr_q   <= 2'd0;
      lk_tag_q     <= '0;
    end else begin
      resp_v_q <= lookup_valid;
      if (lookup_valid) begin
        snap_valid_q <= valid_q[lk_idx];
        snap_tag_q   <= tag_q[lk_idx];
        snap_ctr_q   <= ctr_q[lk_idx];
        lk_tag_q     <= lk_tag;
      end
    end
  end

  assign resp_valid  = resp_v_q;
  assign resp_hit    = resp_v_q && snap_valid_q && (snap_tag_q == lk_tag_q);
  assign resp_taken  = resp_hit && snap_ctr_q[1];
  assign resp_target = sram_dout0;

  logic unused_bits;
  assign unused_bits = ^{sram_dout1, lookup_pc[1:0], update_pc[1:0]};

endmodule
